comparator_serial_nbit: RTL
===========================

// Module: comparator_serial_nbit
// PURPOSE
//  Multi-cycle MSB-first digit-serial magnitude comparator.
//  - Each cycle compares DIG bits of two BIT-wide operands.
//  - Stops early at the first differing digit.
//  - Unsigned or two's-complement mode.
//  - Start/busy/done handshake; registered one-hot gt/eq/ls result.
//  Area-lean successor to the combinational n-bit comparator, for wide-operand datapaths.
// PARAMETERS
//  BIT     8  operand width; must be a multiple of DIG
//  DIG     2  bits compared per cycle; 1 <= DIG <= BIT
//  SIGNED  0  0 = unsigned compare, 1 = two's-complement compare
// PORTS
//  clk     input   1                   rising-edge clock
//  rst     input   1                   asynchronous, active-high reset
//  start   input   1                   request a compare; accepted only in IDLE
//  num1    input   BIT                 operand A; sampled on accepted start
//  num2    input   BIT                 operand B; sampled on accepted start
//  busy    output  1                   high while state is CMP
//  done    output  1                   one-cycle pulse; result valid
//  gt      output  1                   A > B (registered, held)
//  eq      output  1                   A == B (registered, held)
//  ls      output  1                   A < B (registered, held)
//  cycles  output  $clog2(BIT/DIG)+1   digits examined by last compare
// BEHAVIOUR
//  Reset and state encoding
//  - One clock (clk). Reset is asynchronous and active-high (rst).
//  - Reset values: state=IDLE; busy, done, gt, eq, ls = 0; cycles = 0; shift regs = 0.
//  - States: IDLE, CMP, DONE.
//  Transitions
//  - IDLE -> CMP on start=1.
//      - Load num1/num2 into shift regs a_sr/b_sr; digit counter = 0.
//      - Clear gt/eq/ls to 000.
//      - If SIGNED=1, invert the MSB of both loaded operands (offset binary), so the unsigned digit compare gives a signed result.
//  - CMP, every cycle: compare top DIG bits of a_sr vs b_sr (unsigned).
//      - Digits differ -> set gt or ls; cycles = counter+1; -> DONE.
//      - Digits equal, last digit (counter = BIT/DIG-1) -> eq=1; cycles = BIT/DIG; -> DONE.
//      - Digits equal, not last -> shift both regs left by DIG; counter+1; stay in CMP.
//  - DONE: done=1 for exactly this cycle -> IDLE unconditionally.
//  Latency and outputs
//  - Start accepted at edge E0; done is high in the cycle after edge Ek.
//    k = digits examined, 1..BIT/DIG.
//  - busy=1 exactly while state=CMP; busy and done are never both high.
//  - gt/eq/ls are exactly one-hot from the first done onward.
//    They hold until the next accepted start, which clears them to 000.
//  Handshake and boundary conditions
//  - start in CMP or DONE is ignored; no queuing.
//    num1/num2 may change freely after acceptance.
//  - DIG=BIT: single-cycle compare, k=1 always.
//  - Most negative vs most positive (SIGNED=1) must resolve on the first digit.
//  - rst mid-compare: immediate return to IDLE; all outputs = 0; partial result discarded.
// TESTING (BIT=8, DIG=2 unless noted)
//  1. SIGNED=0: start, num1=0x9C, num2=0x3F
//     -> done 1 cycle after accept; gt=1; cycles=1.
//  2. SIGNED=0: num1=0x55, num2=0x55
//     -> busy high 4 cycles; then done; eq=1; cycles=4.
//  3. SIGNED=0: num1=0x54, num2=0x55
//     -> ls=1; cycles=4.
//  4. SIGNED=1: num1=0xF0 (-16), num2=0x05
//     -> ls=1; cycles=1.
//  5. SIGNED=1: num1=0x80, num2=0x7F
//     -> ls=1; cycles=1.
//  6. Start 0x55/0x55; pulse start with 0x00/0xFF during CMP
//     -> ignored; eq=1; cycles=4.
//  7. Start 0x55/0x55; assert rst after 2 cycles
//     -> outputs all 0 immediately; state IDLE.
//     Next start 0x01/0x00 -> gt=1; cycles=4.

Source files
------------

// File: rtl/comparator_serial_nbit_if.sv
// Handshake and result bundle for the digit-serial magnitude comparator.
// The master drives start and the operands; the comparator (slave) returns status and result.
interface comparator_serial_nbit_if #(
  parameter int BIT = 8,
  parameter int DIG = 2
);
  localparam int CW = $clog2(BIT / DIG) + 1;

  logic           start;
  logic [BIT-1:0] num1;
  logic [BIT-1:0] num2;
  logic           busy;
  logic           done;
  logic           gt;
  logic           eq;
  logic           ls;
  logic [CW-1:0]  cycles;

  modport master (output start, num1, num2,
                  input  busy, done, gt, eq, ls, cycles);
  modport slave  (input  start, num1, num2,
                  output busy, done, gt, eq, ls, cycles);
endinterface

// File: rtl/comparator_serial_nbit.sv
// MSB-first digit-serial magnitude comparator: DIG bits per cycle, early exit on the
// first differing digit, unsigned or two's-complement, one-hot registered gt/eq/ls.
module comparator_serial_nbit #(
  parameter int BIT    = 8,
  parameter int DIG    = 2,
  parameter int SIGNED = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  comparator_serial_nbit_if.slave bus
);
  localparam int ND = BIT / DIG;
  localparam int CW = $clog2(ND) + 1;

  if ((DIG < 1) || (DIG > BIT) || ((BIT % DIG) != 0)) begin : g_bad_param
    $error("comparator_serial_nbit: BIT must be a positive multiple of DIG");
  end

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [BIT-1:0] a_sr_q, a_sr_d;
  logic [BIT-1:0] b_sr_q, b_sr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  cycles_q, cycles_d;
  logic           gt_q, gt_d;
  logic           eq_q, eq_d;
  logic           ls_q, ls_d;

  logic [BIT-1:0] a_ld, b_ld;
  logic [DIG-1:0] a_dig, b_dig;

  assign a_dig = a_sr_q[BIT-1 -: DIG];
  assign b_dig = b_sr_q[BIT-1 -: DIG];

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    ls_d     = ls_q;

    // Flipping the sign bit maps two's-complement onto offset binary, so the
    // unsigned digit compare below orders signed operands correctly.
    a_ld = bus.num1;
    b_ld = bus.num2;
    if (SIGNED != 0) begin
      a_ld[BIT-1] = ~bus.num1[BIT-1];
      b_ld[BIT-1] = ~bus.num2[BIT-1];
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CMP;
          a_sr_d  = a_ld;
          b_sr_d  = b_ld;
          cnt_d   = '0;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          ls_d    = 1'b0;
        end
      end
      S_CMP: begin
        if (a_dig != b_dig) begin
          gt_d     = (a_dig > b_dig);
          ls_d     = (a_dig < b_dig);
          cycles_d = cnt_q + CW'(1);
          state_d  = S_DONE;
        end else if (cnt_q == CW'(ND - 1)) begin
          eq_d     = 1'b1;
          cycles_d = CW'(ND);
          state_d  = S_DONE;
        end else begin
          a_sr_d = a_sr_q << DIG;
          b_sr_d = b_sr_q << DIG;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the shift registers are reset along with the control state so a reset compare leaves no stale operand bits behind.
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      cnt_q    <= '0;
      cycles_q <= '0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      ls_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      ls_q     <= ls_d;
    end
  end

  assign bus.busy   = (state_q == S_CMP);
  assign bus.done   = (state_q == S_DONE);
  assign bus.gt     = gt_q;
  assign bus.eq     = eq_q;
  assign bus.ls     = ls_q;
  assign bus.cycles = cycles_q;
endmodule
